// File: rtl/pipe_add32_if.sv
// Handshake and data bundle for the two-stage 32-bit adder/subtractor.
// The slave side is the adder itself; the master side is the producer/consumer.
interface pipe_add32_if;
  // Operand side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  // Result side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        zero;
  logic        sign;
  logic        ovf;

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, zero, sign, ovf
  );

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, zero, sign, ovf
  );
endinterface

// File: rtl/pipe_add32.sv
// Two-stage pipelined 32-bit adder/subtractor with valid/ready handshakes.
// Stage 1 adds the low halves, stage 2 adds the high halves with the carry
// from stage 1 and registers the result and flags. Both 16-bit adders are
// built from four 4-bit carry-lookahead groups with a lookahead group carry.
module pipe_add32 (
  input  logic               clk,
  input  logic               rst,
  pipe_add32_if.slave        bus
);

  // 16-bit two-level carry-lookahead adder: returns {carry_out, sum}.
  function automatic logic [16:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    g = x & y;
    p = x ^ y;
    // Group generate / propagate for each nibble
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group carries come straight from the lookahead terms, never rippled
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    // Bit carries inside each group, seeded by that group's carry-in
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    return {gc[4], p ^ c};
  endfunction

  // Stage 1 state
  logic        s1_valid_r;
  logic [15:0] s1_sum_lo_r;
  logic        s1_c16_r;
  logic [15:0] s1_a_hi_r;
  logic [15:0] s1_b_hi_r;

  // Stage 2 / output state
  logic        out_valid_r;
  logic [31:0] sum_r;
  logic        cout_r;
  logic        zero_r;
  logic        sign_r;
  logic        ovf_r;

  // Combinational datapath and handshake terms
  logic [31:0] b_eff_s;
  logic [16:0] lo_s;
  logic [16:0] hi_s;
  logic        ovf_s;
  logic        out_adv_s;
  logic        s2_load_s;
  logic        in_ready_s;
  logic        in_fire_s;

  // Handshake: stage 2 may advance when empty or being drained this cycle
  always_comb begin
    out_adv_s  = !out_valid_r || bus.out_ready;
    s2_load_s  = s1_valid_r && out_adv_s;
    in_ready_s = !s1_valid_r || out_adv_s;
    in_fire_s  = bus.in_valid && in_ready_s;
  end

  // Datapath: low half from the live operands, high half from stage-1 registers
  always_comb begin
    b_eff_s = bus.b ^ {32{bus.sub}};
    lo_s    = cla16(bus.a[15:0], b_eff_s[15:0], bus.sub);
    hi_s    = cla16(s1_a_hi_r, s1_b_hi_r, s1_c16_r);
    ovf_s   = (s1_a_hi_r[15] == s1_b_hi_r[15]) && (hi_s[15] != s1_a_hi_r[15]);
  end

  // Stage 1 register: capture low-half result and high operands on input transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r  <= 1'b0;
      s1_sum_lo_r <= 16'h0000;
      s1_c16_r    <= 1'b0;
      s1_a_hi_r   <= 16'h0000;
      s1_b_hi_r   <= 16'h0000;
    end else if (in_fire_s) begin
      s1_valid_r  <= 1'b1;
      s1_sum_lo_r <= lo_s[15:0];
      s1_c16_r    <= lo_s[16];
      s1_a_hi_r   <= bus.a[31:16];
      s1_b_hi_r   <= b_eff_s[31:16];
    end else if (s2_load_s) begin
      s1_valid_r  <= 1'b0;
    end
  end

  // Stage 2 register: complete the high half and hold results until consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= 32'h0000_0000;
      cout_r      <= 1'b0;
      zero_r      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_r <= 1'b1;
      sum_r       <= {hi_s[15:0], s1_sum_lo_r};
      cout_r      <= hi_s[16];
      zero_r      <= (hi_s[15:0] == 16'h0000) && (s1_sum_lo_r == 16'h0000);
      sign_r      <= hi_s[15];
      ovf_r       <= ovf_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.zero      = zero_r;
  assign bus.sign      = sign_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_add32.sv
// Self-checking bench for pipe_add32: directed vector table, backpressure,
// streaming and asynchronous-reset sequences.
module tb_pipe_add32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pipe_add32_if bus();

  pipe_add32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        zero;
    logic        sign;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];
  logic [35:0] stream_exp[100];
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rs;
  logic        got_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {bus.sum, bus.cout, bus.zero, bus.sign, bus.ovf};
  endfunction

  // Reference arithmetic on 33-bit integers
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] r;
    logic signed [32:0] sr;
    logic ov;
    if (sub) begin
      r  = {1'b0, a} + {1'b0, ~b} + 33'd1;
      sr = $signed({a[31], a}) - $signed({b[31], b});
    end else begin
      r  = {1'b0, a} + {1'b0, b};
      sr = $signed({a[31], a}) + $signed({b[31], b});
    end
    ov = (sr[32] != sr[31]);
    return {r[31:0], r[32], (r[31:0] == 32'd0), r[31], ov};
  endfunction

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("reset_outs", {27'd0, bus.out_valid, outs()}, 64'd0);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table, one operand set at a time
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      bus.sub      = vecs[i].sub;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("vec_latency_early", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      chk("vec_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("vec_result", {28'd0, outs()},
          {28'd0, vecs[i].sum, vecs[i].cout, vecs[i].zero, vecs[i].sign, vecs[i].ovf});
    end
    @(negedge clk);
    chk("vec_drained", {63'd0, bus.out_valid}, 64'd0);

    // Backpressure: A=1+2, B=0x10-3, C=0xFFFF0000+0x00010000
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 32'h0000_0001; bus.b = 32'h0000_0002; bus.sub = 1'b0;
    chk("bp_ready_a", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.a = 32'h0000_0010; bus.b = 32'h0000_0003; bus.sub = 1'b1;
    chk("bp_ready_b", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.a = 32'hFFFF_0000; bus.b = 32'h0001_0000; bus.sub = 1'b0;
    chk("bp_ready_c_blocked", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_out_a", {27'd0, bus.out_valid, outs()}, {27'd0, 1'b1, 32'h0000_0003, 4'b0000});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_hold_out", {27'd0, bus.out_valid, outs()}, {27'd0, 1'b1, 32'h0000_0003, 4'b0000});
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_out_b", {27'd0, bus.out_valid, outs()}, {27'd0, 1'b1, 32'h0000_000D, 4'b1000});
    @(negedge clk);
    chk("bp_out_c", {27'd0, bus.out_valid, outs()}, {27'd0, 1'b1, 32'h0000_0000, 4'b1100});
    @(negedge clk);
    chk("bp_drained", {63'd0, bus.out_valid}, 64'd0);

    // Streaming: 100 back-to-back operand sets, result two cycles later
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(1, 0));
        if (i == 3) begin ra = 32'h7FFF_FFFF; rb = 32'h0000_0001; rs = 1'b0; end
        if (i == 4) begin ra = 32'h8000_0000; rb = 32'h0000_0001; rs = 1'b1; end
        stream_exp[i] = model(ra, rb, rs);
        bus.in_valid = 1'b1;
        bus.a = ra; bus.b = rb; bus.sub = rs;
        chk("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (i >= 2) begin
        chk("stream_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stream_result", {28'd0, outs()}, {28'd0, stream_exp[i-2]});
      end else begin
        chk("stream_empty", {63'd0, bus.out_valid}, 64'd0);
      end
      @(negedge clk);
    end
    chk("stream_drained", {63'd0, bus.out_valid}, 64'd0);

    // Reset mid-operation with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 32'h0000_1111; bus.b = 32'h0000_2222; bus.sub = 1'b0;
    @(negedge clk);
    bus.a = 32'h0000_3333; bus.b = 32'h0000_4444;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst_pre_full", {62'd0, bus.out_valid, bus.in_ready}, {62'd0, 1'b1, 1'b0});
    #2 rst = 1'b0;
    #1;
    chk("rst_async_clear", {26'd0, bus.out_valid, bus.in_ready, outs()}, {26'd0, 1'b0, 1'b1, 36'd0});
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_stale", {63'd0, bus.out_valid}, 64'd0);
    end
    bus.in_valid = 1'b1;
    bus.a = 32'h0000_0010; bus.b = 32'h0000_0020; bus.sub = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    got_valid = 1'b0;
    for (int k = 0; k < 4 && !got_valid; k++) begin
      @(negedge clk);
      got_valid = bus.out_valid;
    end
    chk("rst_new_valid", {63'd0, got_valid}, 64'd1);
    chk("rst_new_result", {28'd0, outs()}, {28'd0, 32'h0000_0030, 4'b0000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_add32.md
PIPE_ADD32 -- requirements
Module: pipe_add32

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits and split into two 16-bit stages.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 in_valid  input  1  operand set on a, b, sub is valid.
REQ-005 in_ready  output  1  block can accept an operand set this cycle.
REQ-006 a  input  32  first operand.
REQ-007 b  input  32  second operand.
REQ-008 sub  input  1  1 = compute a - b, 0 = compute a + b.
REQ-009 out_valid  output  1  sum and flags are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 sum  output  32  result.
REQ-012 cout  output  1  carry out of bit 31 (for subtract, 1 = no borrow).
REQ-013 zero  output  1  sum == 0.
REQ-014 sign  output  1  sum[31].
REQ-015 ovf  output  1  signed overflow.

Function
REQ-016 Transfer on input SHALL occur when in_valid && in_ready; transfer on output SHALL occur when out_valid && out_ready.
REQ-017 Effective operand b' SHALL be b XOR {32{sub}}, with carry-in = sub.
REQ-018 Stage 1 SHALL, on input transfer, register sum[15:0] = a[15:0] + b'[15:0] + sub, the carry out of bit 15 (c16), a[31:16], b'[31:16], and set s1_valid.
REQ-019 Stage 1 SHALL form its 16-bit sum from four 4-bit carry-lookahead groups, with group carries from group generate/propagate lookahead; no ripple between groups.
REQ-020 Stage 2 SHALL compute the high half as a[31:16] + b'[31:16] + c16 from registered stage-1 data, using the same four-group lookahead structure, and register sum, cout, zero, sign, ovf and out_valid.
REQ-021 ovf SHALL equal (a[31] == b'[31]) && (sum[31] != a[31]).
REQ-022 Latency SHALL be 2 clock edges from input transfer to out_valid high.
REQ-023 Stage 2 SHALL load from stage 1 when s1_valid && (!out_valid || out_ready).
REQ-024 in_ready SHALL equal !s1_valid || (!out_valid || out_ready); it is combinational and does not depend on in_valid.
REQ-025 With out_ready held high, the block SHALL sustain one transfer per cycle with no bubbles.
REQ-026 While out_valid && !out_ready, sum and all flags SHALL hold stable, and stage 1 SHALL hold its contents.
REQ-027 Pipeline full (both stages valid, out_ready low) SHALL drive in_ready low; no operand is dropped or overwritten.
REQ-028 On simultaneous output transfer and input transfer, stage 2 SHALL take the stage-1 data and stage 1 SHALL take the new operands in the same edge.
REQ-029 When stage 1 empties with no new input, s1_valid SHALL clear; when stage 2 drains with stage 1 empty, out_valid SHALL clear.
REQ-030 Results SHALL emerge in acceptance order.
REQ-031 Arithmetic SHALL wrap modulo 2^32; any carry beyond bit 31 appears only on cout.

Reset
REQ-032 While rst is low: s1_valid = 0, out_valid = 0, sum = 0, cout = 0, zero = 0, sign = 0, ovf = 0, all stage-1 data registers = 0.
REQ-033 in_ready SHALL be 1 while rst is low.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight results; no stale result appears after rst returns high.

Verification
REQ-035 Add a=0xFFFFFFFF, b=0x00000001, sub=0 -> two edges later: sum=0x00000000, cout=1, zero=1, sign=0, ovf=0 (exercises c16 crossing between stages).
REQ-036 Add a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, sign=1, cout=0.
REQ-037 Subtract a=5, b=7 -> sum=0xFFFFFFFE, cout=0, sign=1, ovf=0; then a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-038 Backpressure test: out_ready=0, offer three back-to-back operand sets -> only two are accepted and in_ready=0 from the third cycle on; outputs hold stable; raising out_ready drains results in order and accepts the third set.
REQ-039 Streaming test: out_ready=1, 100 random operand sets in consecutive cycles -> in_ready is always 1 and results match a reference model, one per cycle, with 2-cycle latency.
REQ-040 Reset test: drive rst low asynchronously, between edges, with both stages valid -> out_valid=0 and in_ready=1 immediately; after release, no output until a new input transfer.
